// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display controller.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package display_pkg;

  localparam logic [2:0] EST_SUCESSO = 3'b010;
  localparam logic [2:0] EST_PARCIAL = 3'b011;
  localparam logic [2:0] EST_FALHA   = 3'b100;

  localparam logic [6:0] SEG_DIG [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_S       = 7'b0010010;
  localparam logic [6:0] SEG_P       = 7'b0001100;
  localparam logic [6:0] SEG_F       = 7'b0001110;
  localparam logic [6:0] SEG_TRACO   = 7'b0111111;
  localparam logic [6:0] SEG_APAGADO = 7'h7F;

  // Decimal digits the converter must hold: enough for 2^pos_w-1 and never
  // fewer than the display, so overflow shows up as a nonzero digit above it.
  // 30103/100000 approximates log10(2).
  function automatic int bcd_digits(input int pos_w, input int n_digits);
    int needed;
    needed = (pos_w * 30103) / 100000 + 1;
    return (needed > n_digits) ? needed : n_digits;
  endfunction

  function automatic logic eh_status(input logic [2:0] est);
    return (est == EST_SUCESSO) || (est == EST_PARCIAL) || (est == EST_FALHA);
  endfunction

  function automatic logic [6:0] seg_status(input logic [2:0] est);
    case (est)
      EST_SUCESSO: return SEG_S;
      EST_PARCIAL: return SEG_P;
      EST_FALHA:   return SEG_F;
      default:     return SEG_APAGADO;
    endcase
  endfunction

  function automatic logic [6:0] seg_digito(input logic [3:0] d);
    if (d <= 4'd9) return SEG_DIG[d];
    return SEG_TRACO;
  endfunction

endpackage

// File: rtl/conversor_bin_bcd.sv
// Sequential shift-add-3 binary to BCD converter: one load cycle plus one cycle per
// input bit; done pulses for one cycle with the packed BCD and overflow flag valid.
module conversor_bin_bcd
  import display_pkg::*;
#(
  parameter int POS_W    = 8,
  parameter int N_DIGITS = 4,
  parameter int NB       = bcd_digits(POS_W, N_DIGITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [POS_W-1:0]  bin_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [4*NB-1:0]   bcd_o,
  output logic              overflow_o
);

  localparam int CNT_W = $clog2(POS_W + 1);

  typedef enum logic {
    CONV_OCIOSO,
    CONV_DESLOCANDO
  } conv_estado_t;

  conv_estado_t      estado_q;
  logic [POS_W-1:0]  bin_q;
  logic [4*NB-1:0]   bcd_q;
  logic [4*NB-1:0]   bcd_ajust;
  logic [CNT_W-1:0]  cnt_q;
  logic              done_q;
  logic              overflow;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bcd_ajust = bcd_q;
    for (int k = 0; k < NB; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_ajust[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    overflow = 1'b0;
    for (int k = N_DIGITS; k < NB; k++) begin
      if (bcd_q[4*k +: 4] != 4'd0) overflow = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= CONV_OCIOSO;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        bin_q    <= bin_i;
        bcd_q    <= '0;
        cnt_q    <= CNT_W'(POS_W);
        estado_q <= CONV_DESLOCANDO;
      end else if (estado_q == CONV_DESLOCANDO) begin
        bcd_q <= {bcd_ajust[4*NB-2:0], bin_q[POS_W-1]};
        bin_q <= bin_q << 1;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          estado_q <= CONV_OCIOSO;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign busy_o     = (estado_q == CONV_DESLOCANDO);
  assign done_o     = done_q;
  assign bcd_o      = bcd_q;
  assign overflow_o = overflow;

endmodule

// File: rtl/controlador_display_mux.sv
// N-digit multiplexed seven-segment driver: decimal track position or a blinking
// final-state letter, with all inputs snapshotted once per scan frame.
module controlador_display_mux
  import display_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int POS_W       = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 12500000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          estado_atual,
  input  logic [POS_W-1:0]    posicao_atual,
  output logic [6:0]          segmentos,
  output logic [N_DIGITS-1:0] anodos,
  output logic                bcd_valido
);

  localparam int NB    = bcd_digits(POS_W, N_DIGITS);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = $clog2(BLINK_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DW    = 4 * N_DIGITS;

  localparam logic [REF_W-1:0] REF_FIM = REF_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_FIM = BLK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_ULT = IDX_W'(N_DIGITS - 1);

  if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_chk_digits
    $error("N_DIGITS must be in 1..8");
  end
  if (REFRESH_DIV < 2 || BLINK_DIV < 2) begin : g_chk_div
    $error("REFRESH_DIV and BLINK_DIV must be at least 2");
  end
  if (REFRESH_DIV * N_DIGITS <= POS_W + 1) begin : g_chk_frame
    $error("a scan frame must be longer than one BCD conversion");
  end

  logic [REF_W-1:0]    refresh_q;
  logic [BLK_W-1:0]    blink_q;
  logic                blink_vis_q;
  logic [IDX_W-1:0]    idx_q;
  logic                ativo_q;
  logic [2:0]          est_snap_q;
  logic [DW-1:0]       bcd_q;
  logic                ovf_q;
  logic                valido_q;
  logic [DW-1:0]       disp_bcd_q;
  logic                disp_ovf_q;
  logic                disp_valid_q;
  logic [6:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [N_DIGITS-1:0] nz;
  logic [3:0]          digito;

  logic                fim_refresh;
  logic                inicio_quadro;
  logic                conv_busy;
  logic                conv_done;
  logic [4*NB-1:0]     conv_bcd;
  logic                conv_ovf;

  assign fim_refresh   = (refresh_q == REF_FIM);
  // The very first terminal only enables the scan at digit 0, so it is a frame start too.
  assign inicio_quadro = fim_refresh && (!ativo_q || idx_q == IDX_ULT);

  conversor_bin_bcd #(
    .POS_W    (POS_W),
    .N_DIGITS (N_DIGITS),
    .NB       (NB)
  ) u_conversor (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (inicio_quadro),
    .bin_i      (posicao_atual),
    .busy_o     (conv_busy),
    .done_o     (conv_done),
    .bcd_o      (conv_bcd),
    .overflow_o (conv_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_q   <= '0;
      idx_q       <= '0;
      ativo_q     <= 1'b0;
      blink_q     <= '0;
      blink_vis_q <= 1'b1;
    end else begin
      refresh_q <= fim_refresh ? '0 : refresh_q + REF_W'(1);
      if (fim_refresh) begin
        ativo_q <= 1'b1;
        if (ativo_q) idx_q <= (idx_q == IDX_ULT) ? '0 : idx_q + IDX_W'(1);
      end
      if (blink_q == BLK_FIM) begin
        blink_q     <= '0;
        blink_vis_q <= ~blink_vis_q;
      end else begin
        blink_q <= blink_q + BLK_W'(1);
      end
    end
  end

  // A conversion lands mid-frame in bcd_q; the digits only see it at the next frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      est_snap_q   <= 3'b000;
      bcd_q        <= '0;
      ovf_q        <= 1'b0;
      valido_q     <= 1'b0;
      disp_bcd_q   <= '0;
      disp_ovf_q   <= 1'b0;
      disp_valid_q <= 1'b0;
    end else begin
      if (conv_done) begin
        bcd_q    <= conv_bcd[DW-1:0];
        ovf_q    <= conv_ovf;
        valido_q <= 1'b1;
      end
      if (inicio_quadro) begin
        est_snap_q   <= estado_atual;
        disp_bcd_q   <= bcd_q;
        disp_ovf_q   <= ovf_q;
        disp_valid_q <= valido_q & ~conv_busy;
      end
    end
  end

  // nz[k] is set when digit k or any digit to its left is nonzero (leading-zero blanking).
  always_comb begin
    logic acima;
    acima = 1'b0;
    nz    = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      acima = acima | (disp_bcd_q[4*k +: 4] != 4'd0);
      nz[k] = acima;
    end
  end

  always_comb begin
    seg_d  = SEG_APAGADO;
    an_d   = '1;
    digito = disp_bcd_q[4*idx_q +: 4];
    if (ativo_q) begin
      an_d[idx_q] = 1'b0;
      if (eh_status(est_snap_q)) begin
        if (idx_q == IDX_ULT && blink_vis_q) seg_d = seg_status(est_snap_q);
      end else if (!disp_valid_q) begin
        seg_d = SEG_APAGADO;
      end else if (disp_ovf_q) begin
        seg_d = SEG_TRACO;
      end else if (idx_q == '0 || nz[idx_q]) begin
        seg_d = seg_digito(digito);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_APAGADO;
      an_q  <= '1;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign segmentos  = seg_q;
  assign anodos     = an_q;
  assign bcd_valido = valido_q;

endmodule

// File: tb/tb_controlador_display_mux.sv
// Randomised bench for controlador_display_mux: a 4-digit and a 2-digit instance run side by
// side against a reference model built from edge counts and decimal arithmetic.
module tb_controlador_display_mux;

  localparam int POS_W = 8;
  localparam int BLINK = 16;
  localparam int NI    = 2;
  localparam int N_DIG [NI] = '{4, 2};
  localparam int R_DIV [NI] = '{4, 8};

  localparam logic [6:0] DIG_CODE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] estado;
  logic [7:0] posicao;
  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a;
  logic [1:0] an_b;
  logic       val_a, val_b;

  controlador_display_mux #(
    .N_DIGITS(4), .POS_W(POS_W), .REFRESH_DIV(4), .BLINK_DIV(BLINK)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .estado_atual(estado), .posicao_atual(posicao),
    .segmentos(seg_a), .anodos(an_a), .bcd_valido(val_a)
  );

  controlador_display_mux #(
    .N_DIGITS(2), .POS_W(POS_W), .REFRESH_DIV(8), .BLINK_DIV(BLINK)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .estado_atual(estado), .posicao_atual(posicao),
    .segmentos(seg_b), .anodos(an_b), .bcd_valido(val_b)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  string fase     = "reset";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model state: e counts rising edges since reset release.
  int         e;
  int         snap_pos [NI];
  int         disp_pos [NI];
  bit         have_snap [NI];
  bit         disp_ok [NI];
  int         est_frame [NI];
  logic [6:0] exp_seg [NI];
  logic [7:0] exp_an [NI];
  bit         exp_val [NI];

  function automatic int pow10(input int k);
    int r;
    r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] ref_seg(input int n, input int idx, input int est,
                                         input int pos, input bit ok, input bit vis);
    if (est == 2 || est == 3 || est == 4) begin
      if (idx != n - 1 || !vis) return 7'h7F;
      return (est == 2) ? 7'b0010010 : (est == 3) ? 7'b0001100 : 7'b0001110;
    end
    if (!ok) return 7'h7F;
    if (pos > pow10(n) - 1) return 7'b0111111;
    if (idx > 0 && pos < pow10(idx)) return 7'h7F;
    return DIG_CODE[(pos / pow10(idx)) % 10];
  endfunction

  task automatic model_reset();
    e = 0;
    for (int k = 0; k < NI; k++) begin
      snap_pos[k]  = 0;
      disp_pos[k]  = 0;
      have_snap[k] = 1'b0;
      disp_ok[k]   = 1'b0;
      est_frame[k] = 0;
      exp_seg[k]   = 7'h7F;
      exp_an[k]    = 8'((1 << N_DIG[k]) - 1);
      exp_val[k]   = 1'b0;
    end
  endtask

  // Outputs after this edge reflect the model state left by the previous edge.
  task automatic model_edge();
    int  n, r, idx;
    bit  act, vis;
    logic [7:0] mask;
    for (int k = 0; k < NI; k++) begin
      n    = N_DIG[k];
      r    = R_DIV[k];
      mask = 8'((1 << n) - 1);
      act  = (e >= r);
      idx  = act ? ((e - r) / r) % n : 0;
      vis  = ((e / BLINK) % 2) == 0;
      exp_seg[k] = act ? ref_seg(n, idx, est_frame[k], disp_pos[k], disp_ok[k], vis) : 7'h7F;
      exp_an[k]  = act ? (~(8'd1 << idx) & mask) : mask;
    end
    e++;
    for (int k = 0; k < NI; k++) begin
      n = N_DIG[k];
      r = R_DIV[k];
      if (e >= r && (e - r) % (r * n) == 0) begin
        disp_pos[k]  = snap_pos[k];
        disp_ok[k]   = have_snap[k];
        snap_pos[k]  = int'(posicao);
        have_snap[k] = 1'b1;
        est_frame[k] = int'(estado);
      end
      exp_val[k] = (e >= r + POS_W + 1);
    end
  endtask

  task automatic compare_all();
    check($sformatf("%s seg4 e=%0d", fase, e), 32'(seg_a), 32'(exp_seg[0]));
    check($sformatf("%s an4 e=%0d", fase, e), 32'(an_a), 32'(exp_an[0]));
    check($sformatf("%s val4 e=%0d", fase, e), 32'(val_a), 32'(exp_val[0]));
    check($sformatf("%s seg2 e=%0d", fase, e), 32'(seg_b), 32'(exp_seg[1]));
    check($sformatf("%s an2 e=%0d", fase, e), 32'(an_b), 32'(exp_an[1]));
    check($sformatf("%s val2 e=%0d", fase, e), 32'(val_b), 32'(exp_val[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  // Called at a falling edge: asserts reset between clock edges and checks it bites at once.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    fase = "rst_async";
    compare_all();
    run(2);
    rst_n = 1'b1;
  endtask

  task automatic random_run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 9) == 0) estado = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) posicao = 8'($urandom);
      tick();
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    estado  = 3'd0;
    posicao = 8'd5;
    model_reset();
    run(3);
    rst_n = 1'b1;

    fase = "pos5";      run(60);
    fase = "pos255";    posicao = 8'd255; run(50);
    fase = "pos0";      posicao = 8'd0;   run(50);
    fase = "falha";     estado = 3'b100;  run(80);
    fase = "sucesso";   estado = 3'b010;  run(40);
    fase = "parcial";   estado = 3'b011;  run(40);
    fase = "pos7";      estado = 3'b000;  posicao = 8'd7; run(40);
    run(6);
    fase = "pos9_mid";  posicao = 8'd9;   run(40);
    fase = "pos150";    posicao = 8'd150; run(40);
    fase = "pos99";     posicao = 8'd99;  run(40);
    fase = "pos100";    posicao = 8'd100; run(40);
    fase = "random";    random_run(1500);

    run(7);
    pulse_reset();
    fase = "post_rst1"; run(7);
    pulse_reset();
    fase = "post_rst2"; random_run(400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
